// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned MAX_DATA_BYTES = 8;
    localparam logic [7:0]  CHK_GOOD       = 8'h00;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_PAYLOAD = 2'd1,
        RX_CHK     = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_cmd_framer_uart.sv
// Bit-level 8N1 UART transceiver: oversampled receiver with held rx_rdy, single-byte transmitter.
module uart_cmd_framer_uart
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_rdy,
    input  logic              clr_rx_rdy,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              trmt,
    output logic              tx_done
);

    localparam int unsigned      BAUD_W     = $clog2(BAUD_DIV + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
    // Start count compensates the two-flop synchroniser so samples land mid-bit.
    localparam logic [BAUD_W-1:0] BAUD_START = BAUD_W'((BAUD_DIV > 2) ? (BAUD_DIV / 2 - 1) : 0);

    logic [1:0]        rx_sync;
    logic              rx_s;
    logic              rx_busy;
    logic [BAUD_W-1:0] rx_baud;
    logic [3:0]        rx_bit;
    logic [BYTE_W-1:0] rx_shift;

    logic [9:0]        tx_sr;
    logic              tx_busy;
    logic [BAUD_W-1:0] tx_baud;
    logic [3:0]        tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx};
    end

    assign rx_s    = rx_sync[1];
    assign rx_data = rx_shift;

    // Receiver: sample 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy  <= 1'b0;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            if (clr_rx_rdy) rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_baud <= BAUD_START;
                    rx_bit  <= '0;
                end
            end else if (rx_baud != '0) begin
                rx_baud <= rx_baud - BAUD_W'(1);
            end else begin
                rx_baud <= BAUD_LAST;
                rx_bit  <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s) rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_rdy  <= 1'b1;
                end else begin
                    rx_shift <= {rx_s, rx_shift[BYTE_W-1:1]};
                end
            end
        end
    end

    // Transmitter: shift out start, 8 data bits, stop; tx_done pulses after the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '1;
            tx_busy <= 1'b0;
            tx_baud <= '0;
            tx_bit  <= '0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (trmt) begin
                    tx_sr   <= {1'b1, tx_data, 1'b0};
                    tx_busy <= 1'b1;
                    tx_baud <= BAUD_LAST;
                    tx_bit  <= '0;
                end
            end else if (tx_baud != '0) begin
                tx_baud <= tx_baud - BAUD_W'(1);
            end else begin
                tx_baud <= BAUD_LAST;
                tx_sr   <= {1'b1, tx_sr[9:1]};
                tx_bit  <= tx_bit + 4'd1;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
            end
        end
    end

    assign tx = tx_sr[0];

endmodule

// File: rtl/uart_cmd_framer.sv
// Command framer: assembles cmd+payload(+checksum) frames from the UART and serialises responses MSB byte first.
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = 2,
    parameter int unsigned RESP_BYTES  = 1,
    parameter int unsigned TIMEOUT_CYC = 65536,
    parameter bit          CHKSUM_EN   = 1'b0,
    parameter int unsigned BAUD_DIV    = 434
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         RX,
    output logic                         TX,
    output logic [BYTE_W-1:0]            cmd,
    output logic [BYTE_W*DATA_BYTES-1:0] data,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    output logic                         frame_err,
    input  logic                         snd_resp,
    input  logic [BYTE_W*RESP_BYTES-1:0] resp,
    output logic                         tx_busy,
    output logic                         resp_sent
);

    localparam int unsigned DATA_W = BYTE_W * DATA_BYTES;
    localparam int unsigned RESP_W = BYTE_W * RESP_BYTES;
    localparam int unsigned CNT_W  = $clog2(DATA_BYTES + 1);
    localparam int unsigned TMO_W  = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned IDX_W  = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BYTES - 1);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_rdy;
    logic              trmt;
    logic              tx_done;
    logic [BYTE_W-1:0] tx_byte;

    uart_cmd_framer_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (RX),
        .tx         (TX),
        .rx_data    (rx_byte),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (rx_rdy),
        .tx_data    (tx_byte),
        .trmt       (trmt),
        .tx_done    (tx_done)
    );

    rx_state_t         rx_state, rx_next;
    logic [BYTE_W-1:0] cmd_work;
    logic [BYTE_W-1:0] sum;
    logic [DATA_W-1:0] data_work;
    logic [DATA_W-1:0] data_shift_c;
    logic [CNT_W-1:0]  byte_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit_c;
    logic              start_c, shift_c, commit_c, chk_bad_c, timeout_c;

    assign data_shift_c = DATA_W'({data_work, rx_byte});
    assign tmo_hit_c    = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state; an arriving byte always takes priority over a timeout in the same cycle.
    always_comb begin
        rx_next   = rx_state;
        start_c   = 1'b0;
        shift_c   = 1'b0;
        commit_c  = 1'b0;
        chk_bad_c = 1'b0;
        timeout_c = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_rdy) begin
                    start_c = 1'b1;
                    rx_next = RX_PAYLOAD;
                end
            end
            RX_PAYLOAD: begin
                if (rx_rdy) begin
                    shift_c = 1'b1;
                    if (byte_cnt == CNT_LAST) begin
                        if (CHKSUM_EN) begin
                            rx_next = RX_CHK;
                        end else begin
                            commit_c = 1'b1;
                            rx_next  = RX_IDLE;
                        end
                    end
                end else if (tmo_hit_c) begin
                    timeout_c = 1'b1;
                    rx_next   = RX_IDLE;
                end
            end
            RX_CHK: begin
                if (rx_rdy) begin
                    rx_next = RX_IDLE;
                    if (BYTE_W'(sum + rx_byte) == CHK_GOOD) commit_c  = 1'b1;
                    else                                    chk_bad_c = 1'b1;
                end else if (tmo_hit_c) begin
                    timeout_c = 1'b1;
                    rx_next   = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: working registers, committed frame, flags and inter-byte timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_work  <= '0;
            sum       <= '0;
            data_work <= '0;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (start_c) begin
                cmd_work <= rx_byte;
                sum      <= rx_byte;
                byte_cnt <= '0;
            end
            if (shift_c) begin
                data_work <= data_shift_c;
                sum       <= BYTE_W'(sum + rx_byte);
                byte_cnt  <= byte_cnt + CNT_W'(1);
            end
            if (commit_c) begin
                cmd  <= cmd_work;
                data <= (rx_state == RX_CHK) ? data_work : data_shift_c;
            end
            if (commit_c)                    cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || start_c) cmd_rdy <= 1'b0;
            frame_err <= chk_bad_c | timeout_c;
            if (rx_rdy || rx_state == RX_IDLE) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    tx_state_t         tx_state, tx_next;
    logic [RESP_W-1:0] resp_sh;
    logic [IDX_W-1:0]  idx;
    logic              accept_c, advance_c, last_c;

    assign trmt    = (tx_state == TX_LOAD);
    assign tx_byte = resp_sh[RESP_W-1 -: BYTE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next-state; snd_resp is only honoured from TX_IDLE.
    always_comb begin
        tx_next   = tx_state;
        accept_c  = 1'b0;
        advance_c = 1'b0;
        last_c    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (snd_resp) begin
                    accept_c = 1'b1;
                    tx_next  = TX_LOAD;
                end
            end
            TX_LOAD: tx_next = TX_WAIT;
            TX_WAIT: begin
                if (tx_done) begin
                    if (idx == '0) begin
                        last_c  = 1'b1;
                        tx_next = TX_IDLE;
                    end else begin
                        advance_c = 1'b1;
                        tx_next   = TX_LOAD;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sh   <= '0;
            idx       <= '0;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            if (accept_c) begin
                resp_sh <= resp;
                idx     <= IDX_LAST;
            end else if (advance_c) begin
                resp_sh <= resp_sh << BYTE_W;
                idx     <= idx - IDX_W'(1);
            end
            tx_busy   <= (tx_next != TX_IDLE);
            resp_sent <= last_c;
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench: two framer instances (plain + timeout, and checksummed) driven over serial lines.
module tb_uart_cmd_framer;

    localparam int unsigned BAUD = 8;

    typedef struct packed {
        logic        is_err;
        logic [7:0]  cmd;
        logic [15:0] data;
    } rx_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rx_a, tx_a, cmd_rdy_a, clr_a, ferr_a, snd_a, busy_a, sent_a;
    logic [7:0]  cmd_a;
    logic [15:0] data_a, resp_a;
    logic        rx_b, tx_b, cmd_rdy_b, clr_b, ferr_b, snd_b, busy_b, sent_b;
    logic [7:0]  cmd_b, resp_b;
    logic [15:0] data_b;

    uart_cmd_framer #(.DATA_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYC(100), .CHKSUM_EN(1'b0), .BAUD_DIV(BAUD)) dut_a (
        .clk(clk), .rst_n(rst_n), .RX(rx_a), .TX(tx_a), .cmd(cmd_a), .data(data_a),
        .cmd_rdy(cmd_rdy_a), .clr_cmd_rdy(clr_a), .frame_err(ferr_a), .snd_resp(snd_a),
        .resp(resp_a), .tx_busy(busy_a), .resp_sent(sent_a)
    );

    uart_cmd_framer #(.DATA_BYTES(2), .RESP_BYTES(1), .TIMEOUT_CYC(0), .CHKSUM_EN(1'b1), .BAUD_DIV(BAUD)) dut_b (
        .clk(clk), .rst_n(rst_n), .RX(rx_b), .TX(tx_b), .cmd(cmd_b), .data(data_b),
        .cmd_rdy(cmd_rdy_b), .clr_cmd_rdy(clr_b), .frame_err(ferr_b), .snd_resp(snd_b),
        .resp(resp_b), .tx_busy(busy_b), .resp_sent(sent_b)
    );

    rx_exp_t    rxq_a[$];
    rx_exp_t    rxq_b[$];
    logic [7:0] txq_a[$];
    logic [7:0] txq_b[$];
    int         sent_exp_a, sent_exp_b;
    int         total, bad, epoch;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic rx_exp_t mk(input logic is_err, input logic [7:0] c, input logic [15:0] d);
        rx_exp_t e;
        e.is_err = is_err;
        e.cmd    = c;
        e.data   = d;
        return e;
    endfunction

    task automatic rx_event(input int which, input logic is_err, input logic [7:0] c, input logic [15:0] d);
        rx_exp_t e;
        int      n;
        n = (which == 0) ? rxq_a.size() : rxq_b.size();
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL rx%0d_unexpected: got err=%0b cmd=0x%0h data=0x%0h expected nothing", which, is_err, c, d);
        end else begin
            if (which == 0) e = rxq_a.pop_front();
            else            e = rxq_b.pop_front();
            if (e.is_err !== is_err || (!is_err && (c !== e.cmd || d !== e.data))) begin
                bad++;
                $display("FAIL rx%0d_frame: got err=%0b cmd=0x%0h data=0x%0h expected err=%0b cmd=0x%0h data=0x%0h",
                         which, is_err, c, d, e.is_err, e.cmd, e.data);
            end
        end
    endtask

    task automatic sent_event(input int which);
        int n;
        n = (which == 0) ? sent_exp_a : sent_exp_b;
        check($sformatf("resp_sent%0d_expected", which), 64'(n > 0), 64'd1);
        check($sformatf("resp_sent%0d_bytes_done", which),
              64'((which == 0) ? txq_a.size() : txq_b.size()), 64'd0);
        if (which == 0 && sent_exp_a > 0) sent_exp_a--;
        if (which == 1 && sent_exp_b > 0) sent_exp_b--;
    endtask

    // Frame / error / resp_sent monitor, sampled on the falling edge.
    logic rdy_q_a, rdy_q_b, rxr_q_a, rxr_q_b;
    initial begin
        rdy_q_a = 1'b0; rdy_q_b = 1'b0; rxr_q_a = 1'b0; rxr_q_b = 1'b0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr_a) rx_event(0, 1'b1, 8'h00, 16'h0000);
            if (ferr_b) rx_event(1, 1'b1, 8'h00, 16'h0000);
            if (cmd_rdy_a && !rdy_q_a) begin
                rx_event(0, 1'b0, cmd_a, data_a);
                check("cmd_rdy_latency_a", 64'(rxr_q_a), 64'd1);
            end
            if (cmd_rdy_b && !rdy_q_b) begin
                rx_event(1, 1'b0, cmd_b, data_b);
                check("cmd_rdy_latency_b", 64'(rxr_q_b), 64'd1);
            end
            if (sent_a) sent_event(0);
            if (sent_b) sent_event(1);
        end
        rdy_q_a = rst_n && cmd_rdy_a;
        rdy_q_b = rst_n && cmd_rdy_b;
        rxr_q_a = dut_a.rx_rdy;
        rxr_q_b = dut_b.rx_rdy;
    end

    function automatic logic tx_line(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction

    // Serial decoder on a TX line; bytes cut short by a reset are discarded.
    task automatic tx_decode(input int which);
        logic [7:0] b;
        logic       stop;
        int         ep;
        @(negedge clk);
        while (!rst_n || tx_line(which) !== 1'b0) @(negedge clk);
        ep = epoch;
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = tx_line(which);
        end
        repeat (BAUD) @(negedge clk);
        stop = tx_line(which);
        if (ep == epoch) begin
            if (((which == 0) ? txq_a.size() : txq_b.size()) == 0) begin
                total++;
                bad++;
                $display("FAIL tx%0d_unexpected: got byte=0x%0h expected nothing", which, b);
            end else if (which == 0) begin
                check("tx_a_byte", 64'({stop, b}), 64'({1'b1, txq_a.pop_front()}));
            end else begin
                check("tx_b_byte", 64'({stop, b}), 64'({1'b1, txq_b.pop_front()}));
            end
        end
    endtask

    initial forever tx_decode(0);
    initial forever tx_decode(1);

    task automatic send_byte(input int which, input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            if (which == 0) rx_a = f[i];
            else            rx_b = f[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int which, input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d0);
        send_byte(which, c);
        send_byte(which, d1);
        send_byte(which, d0);
    endtask

    task automatic pulse_snd(input int which);
        @(posedge clk); #1;
        if (which == 0) snd_a = 1'b1; else snd_b = 1'b1;
        @(posedge clk); #1;
        snd_a = 1'b0;
        snd_b = 1'b0;
    endtask

    task automatic wait_tx_idle(input int which);
        int n;
        n = 0;
        while (((which == 0) ? busy_a : busy_b) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("tx%0d_completes", which), 64'((which == 0) ? busy_a : busy_b), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; epoch = 0; sent_exp_a = 0; sent_exp_b = 0;
        rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        snd_a = 1'b0; snd_b = 1'b0; resp_a = 16'h0000; resp_b = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", {cmd_a, data_a, cmd_rdy_a, ferr_a, busy_a, sent_a, tx_a}, {24'h0, 4'b0000, 1'b1});
        check("reset_b", {cmd_b, data_b, cmd_rdy_b, ferr_b, busy_b, sent_b, tx_b}, {24'h0, 4'b0000, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Basic frame.
        rxq_a.push_back(mk(1'b0, 8'hA5, 16'h1234));
        send_frame(0, 8'hA5, 8'h12, 8'h34);
        @(negedge clk);
        check("cmd_rdy_a_set", 64'(cmd_rdy_a), 64'd1);

        // First byte of a new frame drops cmd_rdy; old frame held until commit.
        send_byte(0, 8'h01);
        repeat (2) @(negedge clk);
        check("cmd_rdy_a_dropped", 64'(cmd_rdy_a), 64'd0);
        check("old_frame_held", {cmd_a, data_a}, {8'hA5, 16'h1234});
        @(posedge clk); #1; clr_a = 1'b1;
        @(posedge clk); #1; clr_a = 1'b0;
        rxq_a.push_back(mk(1'b0, 8'h01, 16'h0203));
        send_byte(0, 8'h02);
        send_byte(0, 8'h03);
        @(negedge clk);
        check("cmd_rdy_a_set2", 64'(cmd_rdy_a), 64'd1);
        @(posedge clk); #1; clr_a = 1'b1;
        @(posedge clk); #1; clr_a = 1'b0;
        @(negedge clk);
        check("clr_cmd_rdy", 64'(cmd_rdy_a), 64'd0);
        check("data_held_after_clr", {cmd_a, data_a}, {8'h01, 16'h0203});

        // Timeout mid-frame, then a clean frame.
        rxq_a.push_back(mk(1'b1, 8'h00, 16'h0000));
        send_byte(0, 8'h55);
        send_byte(0, 8'h01);
        repeat (130) @(posedge clk);
        @(negedge clk);
        check("timeout_keeps_frame", {cmd_rdy_a, cmd_a, data_a}, {1'b0, 8'h01, 16'h0203});
        rxq_a.push_back(mk(1'b0, 8'h66, 16'hABCD));
        send_frame(0, 8'h66, 8'hAB, 8'hCD);

        // Inter-byte gap just under the timeout must not abort.
        rxq_a.push_back(mk(1'b0, 8'h77, 16'h8899));
        send_byte(0, 8'h77);
        repeat (10) @(posedge clk);
        send_byte(0, 8'h88);
        send_byte(0, 8'h99);

        // Two-byte response, MSB first; a second request while busy is ignored.
        resp_a = 16'hBEEF;
        txq_a.push_back(8'hBE);
        txq_a.push_back(8'hEF);
        sent_exp_a++;
        pulse_snd(0);
        @(negedge clk);
        check("tx_busy_a", 64'(busy_a), 64'd1);
        repeat (20) @(posedge clk);
        resp_a = 16'h1111;
        pulse_snd(0);
        wait_tx_idle(0);
        repeat (120) @(posedge clk);

        // Checksummed instance: good, bad, good.
        rxq_b.push_back(mk(1'b0, 8'h10, 16'h2030));
        send_frame(1, 8'h10, 8'h20, 8'h30);
        send_byte(1, 8'hA0);
        @(negedge clk);
        check("chk_good_cmd_rdy", 64'(cmd_rdy_b), 64'd1);
        rxq_b.push_back(mk(1'b1, 8'h00, 16'h0000));
        send_frame(1, 8'h10, 8'h20, 8'h30);
        send_byte(1, 8'hA1);
        repeat (3) @(negedge clk);
        check("chk_bad_no_commit", {cmd_rdy_b, cmd_b, data_b}, {1'b0, 8'h10, 16'h2030});
        rxq_b.push_back(mk(1'b0, 8'h01, 16'h0203));
        send_frame(1, 8'h01, 8'h02, 8'h03);
        send_byte(1, 8'hFA);

        // Single-byte response on the checksummed instance.
        resp_b = 8'h5A;
        txq_b.push_back(8'h5A);
        sent_exp_b++;
        pulse_snd(1);
        wait_tx_idle(1);
        repeat (20) @(posedge clk);

        // Reset mid-frame and mid-response.
        send_byte(0, 8'hA5);
        resp_a = 16'hCAFE;
        pulse_snd(0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        epoch++;
        rxq_a.delete(); txq_a.delete(); sent_exp_a = 0;
        repeat (2) @(negedge clk);
        check("midreset_a", {cmd_a, data_a, cmd_rdy_a, ferr_a, busy_a, sent_a, tx_a}, {24'h0, 4'b0000, 1'b1});
        check("midreset_b", {cmd_b, data_b, cmd_rdy_b, ferr_b, busy_b, sent_b, tx_b}, {24'h0, 4'b0000, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        rxq_a.push_back(mk(1'b0, 8'h3C, 16'h5AC3));
        send_frame(0, 8'h3C, 8'h5A, 8'hC3);
        resp_a = 16'h1234;
        txq_a.push_back(8'h12);
        txq_a.push_back(8'h34);
        sent_exp_a++;
        pulse_snd(0);
        wait_tx_idle(0);
        repeat (150) @(posedge clk);

        check("rxq_a_drained", 64'(rxq_a.size()), 64'd0);
        check("rxq_b_drained", 64'(rxq_b.size()), 64'd0);
        check("txq_a_drained", 64'(txq_a.size()), 64'd0);
        check("txq_b_drained", 64'(txq_b.size()), 64'd0);
        check("resp_sent_a_count", 64'(sent_exp_a), 64'd0);
        check("resp_sent_b_count", 64'(sent_exp_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
